// File: rtl/mv_select_pkg.sv
// Shared block-matching parameters: search block size macros and the mv_select FSM encoding.
// Latency: none. This package holds only types and constants.
// Backpressure: not applicable.
`ifndef MV_SELECT_PKG_SV
`define MV_SELECT_PKG_SV

`ifndef BLK_SIZE
`define BLK_SIZE 8
`endif
`ifndef BS_SQ
`define BS_SQ ((`BLK_SIZE) * (`BLK_SIZE))
`endif
`ifndef BS_CUBE
`define BS_CUBE ((`BLK_SIZE) * (`BLK_SIZE) * (`BLK_SIZE))
`endif

package mv_select_pkg;

  // Candidate results per search block. This is the default for mv_select N_CAND.
  localparam int BLK_SIZE = `BLK_SIZE;
  localparam int BS_SQ    = `BS_SQ;
  localparam int BS_CUBE  = `BS_CUBE;

  // Selector FSM: waiting for the first candidate, comparing the rest, holding the result.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } mv_state_e;

endpackage

`endif

// File: rtl/mv_select.sv
// Picks the minimum-SAD motion vector from N_CAND candidates per search block; ties keep the earlier candidate.
// Latency: mv_valid rises 1 cycle after the last candidate of a block is accepted.
// Backpressure: in_ready is low while a result waits in REPORT. The result is held until mv_ready is high.
// Optional statistics are enabled by defining MV_SELECT_STATS_EN. When it is undefined, the stat ports are tied to 0.
module mv_select
  import mv_select_pkg::*;
#(
  parameter int N_CAND = BLK_SIZE,
  parameter int SAD_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SAD_W-1:0] in_sad,
  input  logic [7:0]       in_mi,
  input  logic [7:0]       in_mj,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [SAD_W-1:0] mv_sad,
  output logic [7:0]       mv_mi,
  output logic [7:0]       mv_mj,
  output logic [7:0]       blk_idx,
  output logic [15:0]      stat_sad_sum,
  output logic [7:0]       stat_blk_cnt
);

  localparam logic [7:0] LAST_CNT = 8'(N_CAND);

  mv_state_e        state, state_nxt;
  logic [7:0]       cand_cnt;
  logic [SAD_W-1:0] best_sad;
  logic [7:0]       best_mi, best_mj;
  logic [7:0]       blk_idx_q;
  logic             accept, xfer, last_cand, better;
  logic             ld_first, ld_next;

  // flush wins over both a candidate acceptance and an output transfer.
  assign accept    = in_valid && in_ready && !flush;
  assign last_cand = (cand_cnt + 8'd1) == LAST_CNT;
  assign better    = in_sad < best_sad;

  // State register. Reset returns to IDLE asynchronously, so mv_valid drops at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake outputs and datapath load strobes.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    mv_valid  = 1'b0;
    ld_first  = 1'b0;
    ld_next   = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          ld_first  = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          ld_next = 1'b1;
          if (last_cand) state_nxt = REPORT;
        end
      end
      REPORT: begin
        in_ready = 1'b0;
        mv_valid = 1'b1;
        if (mv_ready && !flush) begin
          xfer      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Running minimum and candidate count. A strict less-than makes ties keep the earlier vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_cnt <= '0;
      best_sad <= '0;
      best_mi  <= '0;
      best_mj  <= '0;
    end else if (flush) begin
      cand_cnt <= '0;
    end else if (ld_first) begin
      cand_cnt <= 8'd1;
      best_sad <= in_sad;
      best_mi  <= in_mi;
      best_mj  <= in_mj;
    end else if (ld_next) begin
      cand_cnt <= cand_cnt + 8'd1;
      if (better) begin
        best_sad <= in_sad;
        best_mi  <= in_mi;
        best_mj  <= in_mj;
      end
    end else if (xfer) begin
      cand_cnt <= '0;
    end
  end

  // Block index advances only on a completed transfer and wraps naturally at 256.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    blk_idx_q <= '0;
    else if (xfer) blk_idx_q <= blk_idx_q + 8'd1;
  end

  assign mv_sad  = best_sad;
  assign mv_mi   = best_mi;
  assign mv_mj   = best_mj;
  assign blk_idx = blk_idx_q;

`ifdef MV_SELECT_STATS_EN
  // The accumulator is one bit wider than the larger of the two operands, so the saturation test is exact.
  localparam int SUM_W = ((SAD_W > 16) ? SAD_W : 16) + 1;

  logic [15:0]      sad_sum_q;
  logic [7:0]       blk_cnt_q;
  logic [SUM_W-1:0] sum_ext;

  assign sum_ext = SUM_W'(sad_sum_q) + SUM_W'(best_sad);

  // Saturating statistics, updated once per completed transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sad_sum_q <= '0;
      blk_cnt_q <= '0;
    end else if (xfer) begin
      sad_sum_q <= (sum_ext > SUM_W'(16'hFFFF)) ? 16'hFFFF : sum_ext[15:0];
      if (blk_cnt_q != 8'hFF) blk_cnt_q <= blk_cnt_q + 8'd1;
    end
  end

  assign stat_sad_sum = sad_sum_q;
  assign stat_blk_cnt = blk_cnt_q;
`else
  assign stat_sad_sum = '0;
  assign stat_blk_cnt = '0;
`endif

endmodule

// File: tb/tb_mv_select.sv
module tb_mv_select;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_sad = '0;
  logic [7:0] in_mi = '0;
  logic [7:0] in_mj = '0;
  logic       mv_valid;
  logic       mv_ready = 1'b0;
  logic [7:0] mv_sad, mv_mi, mv_mj, blk_idx;
  logic [15:0] stat_sad_sum;
  logic [7:0]  stat_blk_cnt;

  int vecs = 0;
  int errs = 0;

  mv_select #(.N_CAND(4), .SAD_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sad(in_sad), .in_mi(in_mi), .in_mj(in_mj),
    .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_sad(mv_sad), .mv_mi(mv_mi), .mv_mj(mv_mj),
    .blk_idx(blk_idx), .stat_sad_sum(stat_sad_sum), .stat_blk_cnt(stat_blk_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, vecs=%0d", vecs);
    $fatal(1, "watchdog");
  end

  // Sends four candidates back-to-back. Byte k (MSB first) of each vector is candidate k.
  // The task returns on the negedge after the last candidate's accept edge, with in_valid low.
  task automatic feed4(input logic [31:0] sads, input logic [31:0] mis, input logic [31:0] mjs);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sad   = sads[31-8*k -: 8];
      in_mi    = mis[31-8*k -: 8];
      in_mj    = mjs[31-8*k -: 8];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_xfer();
    mv_ready = 1'b1;
    @(negedge clk);
    mv_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vecs++;
    if ({mv_valid, mv_sad, mv_mi, mv_mj, blk_idx, stat_sad_sum, stat_blk_cnt, in_ready} !== {1'b0, 56'd0, 1'b1}) begin
      errs++;
      $display("FAIL reset: mv_valid=%b sad=%0d mi=%0d mj=%0d blk=%0d sum=%0d cnt=%0d rdy=%b, need all 0 and rdy=1",
               mv_valid, mv_sad, mv_mi, mv_mj, blk_idx, stat_sad_sum, stat_blk_cnt, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    feed4({8'd9, 8'd3, 8'd7, 8'd5}, {8'd0, 8'd1, 8'd2, 8'd3}, {8'd0, 8'hFE, 8'd1, 8'd3});
    vecs++;
    if ({mv_valid, in_ready} !== 2'b10) begin
      errs++;
      $display("FAIL basic_latency: mv_valid=%b in_ready=%b, need 1 0", mv_valid, in_ready);
    end
    vecs++;
    if ({mv_sad, mv_mi, mv_mj, blk_idx} !== {8'd3, 8'd1, 8'hFE, 8'd0}) begin
      errs++;
      $display("FAIL basic_result: sad=%0d mi=%h mj=%h blk=%0d, need 3 01 fe 0", mv_sad, mv_mi, mv_mj, blk_idx);
    end
    do_xfer();
    vecs++;
    if ({mv_valid, in_ready, blk_idx} !== {2'b01, 8'd1}) begin
      errs++;
      $display("FAIL basic_xfer: mv_valid=%b in_ready=%b blk=%0d, need 0 1 1", mv_valid, in_ready, blk_idx);
    end
  endtask

  task automatic test_tie_hold();
    feed4({8'd4, 8'd4, 8'd2, 8'd2}, {8'd10, 8'd12, 8'd14, 8'd16}, {8'd11, 8'd13, 8'd15, 8'd17});
    vecs++;
    if ({mv_valid, mv_sad, mv_mi, mv_mj, blk_idx} !== {1'b1, 8'd2, 8'd14, 8'd15, 8'd1}) begin
      errs++;
      $display("FAIL tie_result: v=%b sad=%0d mi=%0d mj=%0d blk=%0d, need 1 2 14 15 1",
               mv_valid, mv_sad, mv_mi, mv_mj, blk_idx);
    end
    // A better candidate offered while in REPORT must be ignored.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_sad   = 8'd0;
      in_mi    = 8'd99;
      in_mj    = 8'd98;
      @(negedge clk);
      vecs++;
      if ({mv_valid, in_ready, mv_sad, mv_mi, mv_mj, blk_idx} !== {2'b10, 8'd2, 8'd14, 8'd15, 8'd1}) begin
        errs++;
        $display("FAIL tie_hold cyc%0d: v=%b rdy=%b sad=%0d mi=%0d mj=%0d blk=%0d, need 1 0 2 14 15 1",
                 c, mv_valid, in_ready, mv_sad, mv_mi, mv_mj, blk_idx);
      end
    end
    in_valid = 1'b0;
    do_xfer();
    vecs++;
    if ({mv_valid, blk_idx} !== {1'b0, 8'd2}) begin
      errs++;
      $display("FAIL tie_xfer: v=%b blk=%0d, need 0 2", mv_valid, blk_idx);
    end
  endtask

  task automatic test_flush();
    // Two candidates, then flush while a zero-SAD candidate is offered. That candidate must be dropped.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sad   = (k == 2) ? 8'd0 : 8'd50;
      in_mi    = 8'd7;
      in_mj    = 8'd7;
      flush    = (k == 2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    vecs++;
    if ({mv_valid, in_ready, blk_idx} !== {2'b01, 8'd2}) begin
      errs++;
      $display("FAIL flush_idle: v=%b rdy=%b blk=%0d, need 0 1 2", mv_valid, in_ready, blk_idx);
    end
    feed4({8'd8, 8'd6, 8'd1, 8'd2}, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8});
    vecs++;
    if ({mv_valid, mv_sad, mv_mi, mv_mj, blk_idx} !== {1'b1, 8'd1, 8'd3, 8'd7, 8'd2}) begin
      errs++;
      $display("FAIL flush_next: v=%b sad=%0d mi=%0d mj=%0d blk=%0d, need 1 1 3 7 2",
               mv_valid, mv_sad, mv_mi, mv_mj, blk_idx);
    end
    do_xfer();
    // A flush during REPORT wins over a simultaneous mv_ready.
    feed4({8'd5, 8'd5, 8'd5, 8'd5}, 32'd0, 32'd0);
    flush    = 1'b1;
    mv_ready = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    mv_ready = 1'b0;
    vecs++;
    if ({mv_valid, in_ready, blk_idx} !== {2'b01, 8'd3}) begin
      errs++;
      $display("FAIL flush_report: v=%b rdy=%b blk=%0d, need 0 1 3", mv_valid, in_ready, blk_idx);
    end
  endtask

  task automatic test_reset_report();
    feed4({8'd20, 8'd30, 8'd40, 8'd10}, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd1, 8'd2, 8'd3, 8'd4});
    vecs++;
    if ({mv_valid, mv_sad} !== {1'b1, 8'd10}) begin
      errs++;
      $display("FAIL rst_pre: v=%b sad=%0d, need 1 10", mv_valid, mv_sad);
    end
    #2 reset = 1'b0;
    #1;
    vecs++;
    if ({mv_valid, mv_sad, mv_mi, mv_mj, blk_idx, stat_sad_sum, stat_blk_cnt, in_ready} !== {1'b0, 56'd0, 1'b1}) begin
      errs++;
      $display("FAIL rst_async: v=%b sad=%0d mi=%0d mj=%0d blk=%0d sum=%0d cnt=%0d rdy=%b, need all 0 and rdy=1",
               mv_valid, mv_sad, mv_mi, mv_mj, blk_idx, stat_sad_sum, stat_blk_cnt, in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_wrap_stats();
    int exp_sum;
    int exp_cnt;
    for (int b = 1; b <= 258; b++) begin
      feed4(32'hFFFF_FFFF, 32'h0102_0304, 32'h0506_0708);
      if (b == 1 || b == 256 || b == 257) begin
        vecs++;
        if ({mv_valid, mv_sad, blk_idx} !== {1'b1, 8'd255, 8'((b - 1) % 256)}) begin
          errs++;
          $display("FAIL wrap blk%0d: v=%b sad=%0d blk=%0d, need 1 255 %0d",
                   b, mv_valid, mv_sad, blk_idx, (b - 1) % 256);
        end
      end
      do_xfer();
      if (b == 10 || b == 255 || b == 257 || b == 258) begin
`ifdef MV_SELECT_STATS_EN
        exp_sum = (255 * b > 65535) ? 65535 : 255 * b;
        exp_cnt = (b > 255) ? 255 : b;
`else
        exp_sum = 0;
        exp_cnt = 0;
`endif
        vecs++;
        if ({stat_sad_sum, stat_blk_cnt} !== {16'(exp_sum), 8'(exp_cnt)}) begin
          errs++;
          $display("FAIL stats after %0d: sum=%0d cnt=%0d, need %0d %0d",
                   b, stat_sad_sum, stat_blk_cnt, exp_sum, exp_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_hold();
    test_flush();
    test_reset_report();
    test_wrap_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
